// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_pkg: shared 1280x1024@60 timing constants and pixel types       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package vga_pkg;

    localparam int C_H_VISIBLE = 1280;
    localparam int C_H_FP      = 48;
    localparam int C_H_SYNC    = 112;
    localparam int C_H_BP      = 248;
    localparam int C_H_TOTAL   = C_H_VISIBLE + C_H_FP + C_H_SYNC + C_H_BP;

    localparam int C_V_VISIBLE = 1024;
    localparam int C_V_FP      = 1;
    localparam int C_V_SYNC    = 3;
    localparam int C_V_BP      = 38;
    localparam int C_V_TOTAL   = C_V_VISIBLE + C_V_FP + C_V_SYNC + C_V_BP;

    localparam int C_COORD_W   = 12;

    typedef logic [C_COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_delay_line: DEPTH-stage shift register, async reset to RESET_VAL|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module vga_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout_o = din_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q[0] <= din_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dout_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_timing_ctrl: raster counters, sync/blank decode, pin alignment  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE  = C_H_VISIBLE,
    parameter int   H_FP       = C_H_FP,
    parameter int   H_SYNC     = C_H_SYNC,
    parameter int   H_BP       = C_H_BP,
    parameter int   V_VISIBLE  = C_V_VISIBLE,
    parameter int   V_FP       = C_V_FP,
    parameter int   V_SYNC     = C_V_SYNC,
    parameter int   V_BP       = C_V_BP,
    parameter logic SYNC_POL   = 1'b1,
    parameter int   PIPE_DELAY = 1
) (
    input  logic                 CLK_VGA,
    input  logic                 RESET,
    input  logic [3:0]           VGA_RED_IN,
    input  logic [3:0]           VGA_GREEN_IN,
    input  logic [3:0]           VGA_BLUE_IN,
    output logic [C_COORD_W-1:0] VGA_HORZ_COORD,
    output logic [C_COORD_W-1:0] VGA_VERT_COORD,
    output logic                 VGA_ACTIVE,
    output logic                 VGA_FRAME_START,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic [3:0]           VGA_RED,
    output logic [3:0]           VGA_GREEN,
    output logic [3:0]           VGA_BLUE
);

    localparam int     H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    coord_t     h_q, h_d, v_q, v_d;
    logic       active_raw, hs_raw, vs_raw;
    logic [2:0] dly_out;
    rgb444_t    rgb_in, rgb_q;
    logic       hs_q, vs_q;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_VGA or posedge RESET) begin
        if (RESET) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign active_raw = (h_q < H_VIS) && (v_q < V_VIS);
    assign hs_raw     = (h_q >= HS_START) && (h_q < HS_END);
    assign vs_raw     = (v_q >= VS_START) && (v_q < VS_END);

    // Gated by RESET so the pulse cannot appear while the raster is held.
    assign VGA_FRAME_START = !RESET && (h_q == '0) && (v_q == '0);
    assign VGA_HORZ_COORD  = h_q;
    assign VGA_VERT_COORD  = v_q;
    assign VGA_ACTIVE      = active_raw;

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (3'b000)
    ) u_align (
        .clk_i  (CLK_VGA),
        .rst_i  (RESET),
        .din_i  ({active_raw, hs_raw, vs_raw}),
        .dout_o (dly_out)
    );

    assign rgb_in = {VGA_RED_IN, VGA_GREEN_IN, VGA_BLUE_IN};

    // Colour arrives PIPE_DELAY clocks after its coordinate; blank it here.
    always_ff @(posedge CLK_VGA or posedge RESET) begin
        if (RESET) begin
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            rgb_q <= '0;
        end else begin
            hs_q  <= dly_out[1] ^ ~SYNC_POL;
            vs_q  <= dly_out[0] ^ ~SYNC_POL;
            rgb_q <= dly_out[2] ? rgb_in : '0;
        end
    end

    assign VGA_HS    = hs_q;
    assign VGA_VS    = vs_q;
    assign VGA_RED   = rgb_q.r;
    assign VGA_GREEN = rgb_q.g;
    assign VGA_BLUE  = rgb_q.b;

endmodule
`default_nettype wire
